// File: rtl/pending_encoder.sv
// Sticky pending-event collector with a registered valid/ready index output.
// Define PENC_RR_EN for round-robin selection; otherwise the lowest pending index wins.
module pending_encoder #(
  parameter int WIDTH = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             en,
  output logic [IDX_W-1:0] out,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] pending,
  output logic             overflow
);

  logic [WIDTH-1:0] pending_r;
  logic [IDX_W-1:0] out_r;
  logic             valid_r;
  logic             overflow_r;
  logic [WIDTH-1:0] in_masked_s;
  logic [WIDTH-1:0] clr_s;
  logic [IDX_W-1:0] sel_s;
  logic             load_s;
`ifdef PENC_RR_EN
  logic [IDX_W-1:0] rr_r;
`endif

  function automatic logic [IDX_W-1:0] lowest_set(input logic [WIDTH-1:0] v);
    lowest_set = {IDX_W{1'b0}};
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = IDX_W'(i);
    end
  endfunction

  // Offsets scanned from largest to smallest so the nearest line after 'last' wins;
  // offset WIDTH wraps back onto 'last' itself.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [WIDTH-1:0] v,
                                               input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] idx;
    rr_pick = last;
    for (int j = WIDTH; j >= 1; j--) begin
      idx = last + IDX_W'(j);
      if (v[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [WIDTH-1:0] one_hot(input logic [IDX_W-1:0] idx);
    one_hot = {{(WIDTH-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Event gating, grant selection and the clear mask for the granted line
  always_comb begin
    if (en) begin
      in_masked_s = in;
    end else begin
      in_masked_s = {WIDTH{1'b0}};
    end
    load_s = (!valid_r || ready) && (|pending_r);
`ifdef PENC_RR_EN
    sel_s = rr_pick(pending_r, rr_r);
`else
    sel_s = lowest_set(pending_r);
`endif
    if (load_s) begin
      clr_s = one_hot(sel_s);
    end else begin
      clr_s = {WIDTH{1'b0}};
    end
  end

  // Pending capture, output slot and overflow flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_r  <= {WIDTH{1'b0}};
      out_r      <= {IDX_W{1'b0}};
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      // A new event on the line being cleared re-sets it in the same edge.
      pending_r  <= (pending_r & ~clr_s) | in_masked_s;
      overflow_r <= |(in_masked_s & pending_r & ~clr_s);
      if (load_s) begin
        out_r   <= sel_s;
        valid_r <= 1'b1;
      end else if (valid_r && ready) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end
  end

`ifdef PENC_RR_EN
  // Round-robin pointer follows the most recent grant
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_r <= IDX_W'(WIDTH - 1);
    end else if (load_s) begin
      rr_r <= sel_s;
    end else begin
      rr_r <= rr_r;
    end
  end
`endif

  assign out      = out_r;
  assign valid    = valid_r;
  assign pending  = pending_r;
  assign overflow = overflow_r;

endmodule
